// File: rtl/ct_merge_arb.sv
// ct_merge_arb: round-robin packet-locking merge of NI ready/valid streams onto one registered output.
module ct_merge_arb #(
  parameter int NI       = 2,
  parameter int WO       = 32,
  parameter int EOP_LOC  = 0,
  parameter int PKT_LOCK = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NI*WO-1:0] i_data,
  input  logic [NI-1:0]    i_valid,
  output logic [NI-1:0]    o_ready,
  output logic [WO-1:0]    o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [NI-1:0]    o_grant
);
  localparam int LW = $clog2(NI);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t        r_state;
  logic [LW-1:0] r_last, w_sel, w_idx;
  logic [WO-1:0] r_data, w_beat;
  logic [NI-1:0] r_grant;
  logic          r_valid, w_load, w_found, w_xfer, w_eop;
  assign w_load = !r_valid | i_ready;
  // While locked the owner is always r_last, so no separate owner register is kept.
  always_comb begin
    w_idx = '0;
    w_sel = r_last;
    w_found = (r_state == LOCKED) & i_valid[r_last];
    if (r_state == IDLE)
      for (int k = NI; k >= 1; k--) begin
        w_idx = LW'((int'(r_last) + k) % NI);
        if (i_valid[w_idx]) begin
          w_sel = w_idx;
          w_found = 1'b1;
        end
      end
  end
  always_comb begin
    w_beat = '0;
    for (int j = 0; j < NI; j++) w_beat = (w_sel == LW'(j)) ? i_data[j*WO +: WO] : w_beat;
  end
  assign w_eop   = w_beat[EOP_LOC];
  assign w_xfer  = w_load & w_found;
  assign o_ready = NI'(w_xfer) << w_sel;
  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_grant = r_grant;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= LW'(NI - 1);
      r_valid <= 1'b0;
      r_data  <= '0;
      r_grant <= '0;
    end else if (w_load) begin
      r_valid <= w_found;
      if (w_found) begin
        r_data <= w_beat;
        r_last <= w_sel;
        if (PKT_LOCK != 0) begin
          r_state <= w_eop ? IDLE : LOCKED;
          r_grant <= w_eop ? '0 : NI'(1) << w_sel;
        end
      end
    end
  end
endmodule

// File: doc/ct_merge_arb.md
Name: ct_merge_arb

Overview:
- Round-robin, packet-locking arbiter plus one output register stage.
- Merges NI ready/valid input streams onto one output. It is the fan-in counterpart of the flow split node in the interconnect.
- Arbitration runs per packet: once an input wins, it owns the output until it sends its end-of-packet beat. Other inputs are stalled meanwhile.
- The output is registered, giving one cycle of latency at full throughput.

Parameters:
- NI, 2: number of inputs, ≥2.
- WO, 32: width of the data stream on each input and on the output.
- EOP_LOC, 0: bit location of the end-of-packet flag within the data stream.
- PKT_LOCK, 1: 1 = hold the grant until the EOP beat; 0 = re-arbitrate every beat and ignore EOP.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- i_data  input  NI*WO  input data; input j occupies [j*WO +: WO].
- i_valid  input  NI  per-input valid.
- o_ready  output  NI  per-input ready (combinational).
- o_data  output  WO  registered output data.
- o_valid  output  1  registered output valid.
- i_ready  input  1  downstream ready.
- o_grant  output  NI  one-hot lock owner while LOCKED; 0 in IDLE (registered).

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - o_valid=0, o_data=0, o_grant=0.
  - State=IDLE.
  - Round-robin pointer last=NI-1, so input 0 has top priority after reset.
- Reset mid-packet abandons the lock and any beat held in the output register.
- load = !o_valid | i_ready. The output register accepts a new beat when it is empty or draining.
- sel (combinational):
  - IDLE: first j with i_valid[j]=1, searching j = last+1, last+2, … mod NI.
  - LOCKED: sel = owner, and only if i_valid[owner]=1.
  - No candidate: sel = none.
- o_ready[j] = load & (sel==j). At most one o_ready is high per cycle. o_ready depends on i_valid by design, since arbitration needs it.
- Transfer occurs on input sel when load=1 and a candidate exists. On the next edge: o_data ← i_data[sel], o_valid ← 1.
- If load=1 and there is no candidate: o_valid ← 0 and o_data holds.
- If load=0: o_data and o_valid hold.
- eop = i_data[sel*WO+EOP_LOC].
- State machine with PKT_LOCK=1:
  - IDLE, transfer with eop=0 → LOCKED; owner ← sel; last ← sel; o_grant ← onehot(sel).
  - IDLE, transfer with eop=1 → stay IDLE (single-beat packet); last ← sel.
  - LOCKED, transfer with eop=1 → IDLE; o_grant ← 0. last is unchanged, since it already equals owner.
  - LOCKED, transfer with eop=0, or no transfer → stay LOCKED.
  - While the owner has i_valid low, the lock holds indefinitely. There is no timeout, and other inputs see o_ready=0.
- With PKT_LOCK=0: always IDLE, o_grant always 0, last ← sel on every transfer.
- Fairness: after input k wins, k becomes lowest priority. Any continuously valid input is granted within NI-1 packets.
- Latency: one cycle from input transfer to o_valid. Throughput: one beat per cycle when i_ready=1.
- No data is dropped or duplicated. Every input handshake (i_valid & o_ready) maps to exactly one output handshake (o_valid & i_ready), in order.

Test Plan:
Common configuration for all scenarios: NI=3, WO=8, EOP_LOC=7, PKT_LOCK=1 unless stated.
1. Reset, then hold i_valid=3'b111 with all beats eop=1 and i_ready=1.
   - Required: grants rotate 0,1,2,0,…; o_ready is one-hot each cycle.
   - Required: o_data appears one cycle after each accept; o_valid is continuous.
2. Input 1 sends 4-beat packet 0x01,0x02,0x03,0x81 while inputs 0 and 2 are valid throughout.
   - Required: all four beats output consecutively; o_grant=3'b010 from the cycle after the first beat until the cycle after 0x81.
   - Required: the next grant goes to input 2.
3. Owner deasserts i_valid mid-packet for 3 cycles while input 0 is valid.
   - Required: o_ready[0] stays 0; after the output drains, o_valid=0 during the gap; the packet then resumes and completes from the owner.
4. i_ready=0 for 2 cycles with o_valid=1.
   - Required: o_data and o_valid hold and all o_ready=0.
   - Required: when i_ready rises, the held beat transfers and a new beat is accepted in the same cycle (no bubble).
5. Assert reset while LOCKED on input 2 with o_valid=1.
   - Required next cycle: o_valid=0, o_grant=0; with all inputs valid, input 0 wins first.
6. PKT_LOCK=0, input 0 multi-beat (eop=0) and input 1 valid.
   - Required: beats interleave 0,1,0,1; o_grant stays 0.
